// File: rtl/uc_result_tx.sv
// Serialises two result words as {1010, max730, max850, even parity}, MSB first, with cs_n/sclk framing.
// Latency: cs_n falls one cycle after load is accepted; done pulses (FRAME_BITS+2)*BIT_CLKS+1 cycles after acceptance.
// Backpressure: load is dropped while busy, and overrun pulses in the following cycle; the frame in flight is unaffected.
module uc_result_tx #(
    parameter int DATLEN   = 12,
    parameter int BIT_CLKS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATLEN-1:0] max730,
    input  logic [DATLEN-1:0] max850,
    output logic              cs_n,
    output logic              sclk,
    output logic              sdo,
    output logic              busy,
    output logic              done,
    output logic              overrun
);
    localparam int FRAME_BITS = 2*DATLEN + 5;
    localparam int PW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam int CW = $clog2(FRAME_BITS);

    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL} state_t;

    state_t                r_state, w_nstate;
    logic [PW-1:0]         r_phase, w_nphase;
    logic [CW-1:0]         r_cnt, w_ncnt;
    logic [FRAME_BITS-1:0] r_shift, w_nshift;
    logic                  w_done;
    logic                  w_last_phase;

    assign w_last_phase = (r_phase == PW'(BIT_CLKS-1));

    always_comb begin
        w_nstate = r_state;
        w_nphase = r_phase;
        w_ncnt   = r_cnt;
        w_nshift = r_shift;
        w_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_nstate = S_LEAD;
                    w_nphase = '0;
                    w_ncnt   = '0;
                    w_nshift = {4'b1010, max730, max850, ^{max730, max850}};
                end
            end
            S_LEAD: begin
                if (w_last_phase) begin
                    w_nstate = S_SHIFT;
                    w_nphase = '0;
                    w_ncnt   = CW'(FRAME_BITS-1);
                end else begin
                    w_nphase = r_phase + 1'b1;
                end
            end
            S_SHIFT: begin
                if (w_last_phase) begin
                    w_nphase = '0;
                    if (r_cnt == '0) begin
                        w_nstate = S_TRAIL;
                    end else begin
                        // Advance to the next bit only at a period boundary so sdo moves at phase 0.
                        w_ncnt   = r_cnt - 1'b1;
                        w_nshift = {r_shift[FRAME_BITS-2:0], 1'b0};
                    end
                end else begin
                    w_nphase = r_phase + 1'b1;
                end
            end
            S_TRAIL: begin
                if (w_last_phase) begin
                    w_nstate = S_IDLE;
                    w_nphase = '0;
                    w_done   = 1'b1;
                end else begin
                    w_nphase = r_phase + 1'b1;
                end
            end
            default: begin
                w_nstate = S_IDLE;
                w_nphase = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_phase <= '0;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_nstate;
            r_phase <= w_nphase;
            r_cnt   <= w_ncnt;
            r_shift <= w_nshift;
        end
    end

    // Outputs are registered from the next-state values so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_n    <= 1'b1;
            sclk    <= 1'b0;
            sdo     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            cs_n    <= (w_nstate == S_IDLE);
            sclk    <= (w_nstate == S_SHIFT) && (w_nphase >= PW'(BIT_CLKS/2));
            sdo     <= ((w_nstate == S_LEAD) || (w_nstate == S_SHIFT)) ? w_nshift[FRAME_BITS-1] : 1'b0;
            busy    <= (w_nstate != S_IDLE);
            done    <= w_done;
            overrun <= load && (r_state != S_IDLE);
        end
    end
endmodule
